ie_arbiter: RTL and testbench



---
 rtl/ie_arbiter_if.sv | 21 ++
 rtl/ie_arbiter.sv | 120 ++++++++++++
 tb/tb_ie_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ie_arbiter_if.sv
// Bundle of IE arbitration signals: requester/IE side (master) and arbiter side (slave).
interface ie_arbiter_if;
  logic [3:0] req;
  logic       job_done;
  logic       tag_status;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       ie_en;
  logic [1:0] ie_sel;
  logic       timeout_err;

  modport master (
    output req, job_done, tag_status,
    input  gnt, done, ie_en, ie_sel, timeout_err
  );

  modport slave (
    input  req, job_done, tag_status,
    output gnt, done, ie_en, ie_sel, timeout_err
  );
endinterface

// File: rtl/ie_arbiter.sv
// Fixed-priority, non-preemptive owner arbiter for the shared IE (INIT > OCU > PARSE > SCU).
// Define IE_ARB_TIMEOUT_EN to build the BUSY watchdog that forces a release and sets timeout_err.
module ie_arbiter #(
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input logic        DOUB_BLF,
  input logic        rst,
  ie_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [3:0] done_reg, done_next;
  logic [1:0] sel_reg, sel_next;
  logic       ie_en_reg;
  logic [3:0] gap_cnt_reg, gap_cnt_next;
  logic [1:0] win;
  logic       any_req;
  logic       owner_req;
  logic       timeout_hit;

  // Lowest set index wins, so scan from the top down and let lower bits overwrite.
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win = 2'(i);
    end
  end

  assign any_req   = |bus.req;
  assign owner_req = bus.req[sel_reg];

  always_ff @(posedge DOUB_BLF) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      done_reg    <= '0;
      sel_reg     <= '0;
      ie_en_reg   <= 1'b0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      sel_reg     <= sel_next;
      ie_en_reg   <= |gnt_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!bus.tag_status && any_req) state_next = BUSY;
      BUSY:    if (bus.job_done || !owner_req || bus.tag_status || timeout_hit)
                 state_next = RELEASE;
      RELEASE: if (gap_cnt_reg == 4'(GAP_CYC - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // job_done outranks abort, kill and timeout so a finished job always reports completion.
  always_comb begin
    gnt_next     = '0;
    done_next    = '0;
    sel_next     = sel_reg;
    gap_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (!bus.tag_status && any_req) begin
          gnt_next = 4'b0001 << win;
          sel_next = win;
        end
      end
      BUSY: begin
        if (bus.job_done)
          done_next = gnt_reg;
        else if (owner_req && !bus.tag_status && !timeout_hit)
          gnt_next = gnt_reg;
      end
      RELEASE: gap_cnt_next = gap_cnt_reg + 4'd1;
      default: ;
    endcase
  end

`ifdef IE_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt_reg;
  logic             err_reg;

  // Counter holds BUSY cycles already elapsed, so the TIMEOUT_CYC-th cycle sees TIMEOUT_CYC-1.
  assign timeout_hit = (state_reg == BUSY) && (to_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge DOUB_BLF) begin
    if (rst) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      to_cnt_reg <= (state_reg == BUSY) ? to_cnt_reg + 1'b1 : '0;
      if (timeout_hit && !bus.job_done) err_reg <= 1'b1;
    end
  end

  assign bus.timeout_err = err_reg;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg      = 32'(TIMEOUT_CYC) ^ 32'(CNT_W);
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.gnt    = gnt_reg;
  assign bus.done   = done_reg;
  assign bus.ie_sel = sel_reg;
  assign bus.ie_en  = ie_en_reg;

endmodule

// File: tb/tb_ie_arbiter.sv
// Scoreboard bench for ie_arbiter: stimulus queues expected grant/done events, a monitor checks them.
module tb_ie_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ie_arbiter_if arb ();

  ie_arbiter #(
    .GAP_CYC    (1),
    .TIMEOUT_CYC(16),
    .CNT_W      (10)
  ) dut (
    .DOUB_BLF(clk),
    .rst     (rst),
    .bus     (arb)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [1:0] sel;
    logic       err;
  } evt_t;

  evt_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic exp_err     = 1'b0;
  bit   stim_done   = 1'b0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input int at, input logic [3:0] g, input logic [3:0] d, input logic [1:0] s);
    evt_t e;
    e.cyc  = at;
    e.gnt  = g;
    e.done = d;
    e.sel  = s;
    e.err  = exp_err;
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  // Stimulus: every expected event carries the cycle at which it must appear.
  initial begin : stimulus
    int g;
    arb.req        = 4'hF;
    arb.job_done   = 1'b0;
    arb.tag_status = 1'b0;
    rst            = 1'b1;
    tick(); tick();

    // Reset release with all requests pending: INIT granted one cycle later.
    rst = 1'b0;
    push(cyc + 1, 4'b0001, 4'b0000, 2'd0);
    tick();
    arb.req = 4'b0001;
    idle(2);
    arb.job_done = 1'b1;
    push(cyc + 1, 4'b0000, 4'b0001, 2'd0);
    tick();
    arb.job_done = 1'b0;
    arb.req      = 4'b0000;
    idle(3);

    // Single PARSE request, completion, regrant after the gap, then abort.
    arb.req = 4'b0100;
    push(cyc + 1, 4'b0100, 4'b0000, 2'd2);
    tick();
    idle(5);
    arb.job_done = 1'b1;
    push(cyc + 1, 4'b0000, 4'b0100, 2'd2);
    tick();
    arb.job_done = 1'b0;
    push(cyc + 2, 4'b0100, 4'b0000, 2'd2);
    idle(4);
    arb.req = 4'b0000;
    push(cyc + 1, 4'b0000, 4'b0000, 2'd2);
    tick();
    idle(3);

    // Request drop coincident with job_done: completion still reported.
    arb.req = 4'b0100;
    push(cyc + 1, 4'b0100, 4'b0000, 2'd2);
    idle(3);
    arb.req      = 4'b0000;
    arb.job_done = 1'b1;
    push(cyc + 1, 4'b0000, 4'b0100, 2'd2);
    tick();
    arb.job_done = 1'b0;
    idle(3);

    // Priority order OCU, PARSE, SCU with a two-cycle ie_en gap between owners.
    arb.req = 4'b1110;
    g = cyc + 1;
    push(g, 4'b0010, 4'b0000, 2'd1);
    for (int o = 1; o <= 3; o++) begin
      while (cyc < g + 2) tick();
      arb.job_done = 1'b1;
      push(cyc + 1, 4'b0000, oh(o), 2'(o));
      tick();
      arb.job_done = 1'b0;
      arb.req[o]   = 1'b0;
      if (o < 3) begin
        g = cyc + 2;
        push(g, oh(o + 1), 4'b0000, 2'(o + 1));
      end
    end
    idle(3);

    // Killed tag blocks grants; a kill during BUSY releases without done.
    arb.tag_status = 1'b1;
    arb.req        = 4'hF;
    idle(20);
    arb.tag_status = 1'b0;
    push(cyc + 1, 4'b0001, 4'b0000, 2'd0);
    idle(3);
    arb.tag_status = 1'b1;
    push(cyc + 1, 4'b0000, 4'b0000, 2'd0);
    tick();
    arb.tag_status = 1'b0;
    arb.req        = 4'b0000;
    idle(3);

    // Long-held grant with no job_done.
    arb.req = 4'b0001;
    push(cyc + 1, 4'b0001, 4'b0000, 2'd0);
`ifdef IE_ARB_TIMEOUT_EN
    g = cyc;
    exp_err = 1'b1;
    push(g + 17, 4'b0000, 4'b0000, 2'd0);
    push(g + 19, 4'b0001, 4'b0000, 2'd0);
    while (cyc < g + 22) tick();
    arb.job_done = 1'b1;
    push(cyc + 1, 4'b0000, 4'b0001, 2'd0);
    tick();
`else
    idle(110);
    arb.job_done = 1'b1;
    push(cyc + 1, 4'b0000, 4'b0001, 2'd0);
    tick();
`endif
    arb.job_done = 1'b0;
    arb.req      = 4'b0000;
    idle(4);
    stim_done = 1'b1;
  end

  initial begin : monitor
    logic [3:0] prev_gnt;
    evt_t       e;
    prev_gnt = 4'b0000;
    forever begin
      @(negedge clk);
      if (stim_done) break;
      if (rst) begin
        vectors++;
        if (arb.gnt !== 4'b0 || arb.done !== 4'b0 || arb.ie_en !== 1'b0 ||
            arb.ie_sel !== 2'd0 || arb.timeout_err !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_state cyc=%0d: gnt=%b done=%b ie_en=%b ie_sel=%0d timeout_err=%b, required all zero",
                   cyc, arb.gnt, arb.done, arb.ie_en, arb.ie_sel, arb.timeout_err);
        end
        prev_gnt = 4'b0000;
        continue;
      end
      vectors++;
      if (arb.ie_en !== (|arb.gnt) || !$onehot0(arb.gnt) || (arb.done !== 4'b0 && arb.gnt !== 4'b0)) begin
        miscompares++;
        $display("FAIL invariant cyc=%0d: gnt=%b done=%b ie_en=%b, required gnt onehot0, ie_en=|gnt, no done with gnt",
                 cyc, arb.gnt, arb.done, arb.ie_en);
      end
      if (arb.gnt !== prev_gnt || arb.done !== 4'b0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event cyc=%0d: gnt=%b done=%b ie_sel=%0d, required no event",
                   cyc, arb.gnt, arb.done, arb.ie_sel);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || arb.gnt !== e.gnt || arb.done !== e.done ||
              arb.ie_sel !== e.sel || arb.timeout_err !== e.err) begin
            miscompares++;
            $display("FAIL event: got cyc=%0d gnt=%b done=%b sel=%0d err=%b, required cyc=%0d gnt=%b done=%b sel=%0d err=%b",
                     cyc, arb.gnt, arb.done, arb.ie_sel, arb.timeout_err,
                     e.cyc, e.gnt, e.done, e.sel, e.err);
          end
        end
      end
      prev_gnt = arb.gnt;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_events: %0d events never seen, required 0 (next due cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    vectors++;
    if (arb.timeout_err !== exp_err) begin
      miscompares++;
      $display("FAIL final_timeout_err: got %b, required %b", arb.timeout_err, exp_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "time limit reached");
  end

endmodule
